// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the program/data memory arbiter.
//   arb_state_e : arbiter FSM state encoding (2-bit)
//   PORT_A/B    : port index constants, also the encoding of owner/last_grant
//   DATA_W      : memory data width
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int unsigned DATA_W = 8;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin pick.
//   req        in  2  request vector, bit PORT_A / bit PORT_B
//   last_grant in  1  port granted most recently
//   valid      out 1  at least one request present
//   pick       out 1  chosen port (meaningful only when valid)
module rr_pick2
    import mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       valid,
    output logic       pick
);

    always_comb begin
        valid = |req;
        pick  = PORT_A;
        // B wins when it is alone, or on a tie when A went last.
        if (req[PORT_B] && (!req[PORT_A] || last_grant == PORT_A))
            pick = PORT_B;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide program/data memory between the CPU
// (port A) and the host/loader (port B). One transaction in flight at a time,
// round-robin on ties, registered read latency of RD_LAT cycles.
//   clk, reset                  clock, async active-low reset
//   a_req/a_we/a_addr/a_wdata   port A request (held until a_ack)
//   a_rdata, a_ack              port A read data and completion pulse
//   b_*                         same for port B
//   gnt_a, gnt_b                port owns memory, ACCESS through DONE
//   mem_raddr, mem_waddr        memory read / write address (registered)
//   mem_data_in, mem_write      memory write data (registered) and strobe
//   mem_data_out                memory read data
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned addr_width = 9,
    parameter int unsigned RD_LAT     = 1
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [addr_width-1:0] a_addr,
    input  logic [DATA_W-1:0]     a_wdata,
    output logic [DATA_W-1:0]     a_rdata,
    output logic                  a_ack,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [addr_width-1:0] b_addr,
    input  logic [DATA_W-1:0]     b_wdata,
    output logic [DATA_W-1:0]     b_rdata,
    output logic                  b_ack,
    output logic                  gnt_a,
    output logic                  gnt_b,
    output logic [addr_width-1:0] mem_raddr,
    output logic [addr_width-1:0] mem_waddr,
    output logic [DATA_W-1:0]     mem_data_in,
    output logic                  mem_write,
    input  logic [DATA_W-1:0]     mem_data_out
);

    arb_state_e state, state_next;

    logic       owner;
    logic       last_grant;
    logic       we_l;
    logic [2:0] cnt;

    logic                  pick_valid;
    logic                  pick;
    logic                  win_we;
    logic [addr_width-1:0] win_addr;
    logic [DATA_W-1:0]     win_wdata;

    rr_pick2 u_pick (
        .req        ({b_req, a_req}),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .pick       (pick)
    );

    always_comb begin
        win_we    = a_we;
        win_addr  = a_addr;
        win_wdata = a_wdata;
        if (pick == PORT_B) begin
            win_we    = b_we;
            win_addr  = b_addr;
            win_wdata = b_wdata;
        end
    end

    always_comb begin
        state_next = state;
        gnt_a      = 1'b0;
        gnt_b      = 1'b0;
        a_ack      = 1'b0;
        b_ack      = 1'b0;
        mem_write  = 1'b0;
        if (state != IDLE) begin
            gnt_a = (owner == PORT_A);
            gnt_b = (owner == PORT_B);
        end
        case (state)
            IDLE:    if (pick_valid) state_next = ACCESS;
            ACCESS: begin
                mem_write  = we_l;
                state_next = we_l ? DONE : RDWAIT;
            end
            RDWAIT:  if (cnt == 3'd1) state_next = DONE;
            DONE: begin
                a_ack      = (owner == PORT_A);
                b_ack      = (owner == PORT_B);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The winner's address/data go straight into the registered memory
    // buses at grant time; those registers double as the request latch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            owner       <= PORT_A;
            last_grant  <= PORT_B;
            we_l        <= 1'b0;
            cnt         <= '0;
            a_rdata     <= '0;
            b_rdata     <= '0;
            mem_raddr   <= '0;
            mem_waddr   <= '0;
            mem_data_in <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner      <= pick;
                        last_grant <= pick;
                        we_l       <= win_we;
                        if (win_we) begin
                            mem_waddr   <= win_addr;
                            mem_data_in <= win_wdata;
                        end else begin
                            mem_raddr <= win_addr;
                        end
                    end
                end
                ACCESS: cnt <= 3'(RD_LAT);
                RDWAIT: begin
                    cnt <= cnt - 3'd1;
                    // Count of 1 is the last RDWAIT cycle: data is valid now.
                    if (cnt == 3'd1) begin
                        if (owner == PORT_A) a_rdata <= mem_data_out;
                        else                 b_rdata <= mem_data_out;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic       clk;
    logic       rst_n;

    logic       a_req, a_we, b_req, b_we;
    logic [8:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;
    logic [7:0] a_rdata, b_rdata;
    logic       a_ack, b_ack, gnt_a, gnt_b;
    logic [8:0] mem_raddr, mem_waddr;
    logic [7:0] mem_data_in, mem_data_out;
    logic       mem_write;

    logic       a3_req, a3_we, b3_req, b3_we;
    logic [8:0] a3_addr, b3_addr;
    logic [7:0] a3_wdata, b3_wdata;
    logic [7:0] a3_rdata, b3_rdata;
    logic       a3_ack, b3_ack, gnt3_a, gnt3_b;
    logic [8:0] mem3_raddr, mem3_waddr;
    logic [7:0] mem3_data_in, mem3_data_out;
    logic       mem3_write;

    int n_vec  = 0;
    int n_miss = 0;

    mem_arbiter #(.addr_width(9), .RD_LAT(1)) dut (
        .clk(clk), .reset(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_ack(a_ack),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_ack(b_ack),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
        .mem_data_in(mem_data_in), .mem_write(mem_write),
        .mem_data_out(mem_data_out)
    );

    mem_arbiter #(.addr_width(9), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(rst_n),
        .a_req(a3_req), .a_we(a3_we), .a_addr(a3_addr), .a_wdata(a3_wdata),
        .a_rdata(a3_rdata), .a_ack(a3_ack),
        .b_req(b3_req), .b_we(b3_we), .b_addr(b3_addr), .b_wdata(b3_wdata),
        .b_rdata(b3_rdata), .b_ack(b3_ack),
        .gnt_a(gnt3_a), .gnt_b(gnt3_b),
        .mem_raddr(mem3_raddr), .mem_waddr(mem3_waddr),
        .mem_data_in(mem3_data_in), .mem_write(mem3_write),
        .mem_data_out(mem3_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: read data appears RD_LAT cycles after the address.
    logic [7:0] mem1 [512];
    logic [7:0] mem3 [512];
    logic [7:0] rd1;
    logic [7:0] p3 [3];

    always @(posedge clk) begin
        if (mem_write) mem1[mem_waddr] <= mem_data_in;
        rd1 <= mem1[mem_raddr];
        if (mem3_write) mem3[mem3_waddr] <= mem3_data_in;
        p3[0] <= mem3[mem3_raddr];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mem_data_out  = rd1;
    assign mem3_data_out = p3[2];

    function automatic logic [7:0] init_val(input logic [8:0] a);
        return a[7:0] ^ 8'h3C;
    endfunction

    function automatic logic any_out1();
        return |{a_rdata, a_ack, b_rdata, b_ack, gnt_a, gnt_b,
                 mem_raddr, mem_waddr, mem_data_in, mem_write};
    endfunction

    function automatic logic any_out3();
        return |{a3_rdata, a3_ack, b3_rdata, b3_ack, gnt3_a, gnt3_b,
                 mem3_raddr, mem3_waddr, mem3_data_in, mem3_write};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic       port;     // 0 = A, 1 = B
        logic       we;
        logic [8:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        int         exp_lat;  // cycle of ack, counting the sample cycle as 0
        logic       pulse_b;  // pulse b_req for one cycle during ACCESS
        logic       hold;     // keep req high across the edge ending DONE
    } vec_t;

    vec_t vt [8];

    task automatic drop_req(input logic port);
        if (port == 1'b0) a_req = 1'b0;
        else              b_req = 1'b0;
    endtask

    // Runs one transaction starting just after a rising edge with the DUT idle.
    task automatic run_txn(input int idx, input vec_t v);
        int lat, wr, acks, oth;
        logic [7:0] rd, other_rd0;
        lat = 0; wr = 0; oth = 0; rd = '0;
        other_rd0 = v.port ? a_rdata : b_rdata;
        if (v.port == 1'b0) begin
            a_we = v.we; a_addr = v.addr; a_wdata = v.wdata; a_req = 1'b1;
        end else begin
            b_we = v.we; b_addr = v.addr; b_wdata = v.wdata; b_req = 1'b1;
        end
        @(posedge clk);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (mem_write) begin
                wr++;
                check($sformatf("v%0d_wr_cycle", idx), k, 1);
                check($sformatf("v%0d_waddr", idx), {23'd0, mem_waddr}, {23'd0, v.addr});
                check($sformatf("v%0d_wdata", idx), {24'd0, mem_data_in}, {24'd0, v.wdata});
            end
            if (k == 1 && !v.we)
                check($sformatf("v%0d_raddr", idx), {23'd0, mem_raddr}, {23'd0, v.addr});
            if (v.pulse_b && k == 1) b_req = 1'b1;
            if (v.pulse_b && k == 2) b_req = 1'b0;
            if (v.port == 1'b0 ? (gnt_b || b_ack) : (gnt_a || a_ack)) oth++;
            if (v.port == 1'b0 ? a_ack : b_ack) begin
                lat = k;
                rd  = v.port ? b_rdata : a_rdata;
                break;
            end
        end
        acks = (lat != 0) ? 1 : 0;
        if (!v.hold) drop_req(v.port);
        @(posedge clk);
        #1;
        drop_req(v.port);
        repeat (4) begin
            @(negedge clk);
            if (mem_write) wr++;
            if (v.port == 1'b0 ? a_ack : b_ack) acks++;
            if (v.port == 1'b0 ? b_ack : a_ack) oth++;
        end
        check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d_ack_count", idx), acks, 1);
        check($sformatf("v%0d_write_count", idx), wr, v.we ? 1 : 0);
        check($sformatf("v%0d_other_port_activity", idx), oth, 0);
        check($sformatf("v%0d_other_rdata", idx), {24'd0, v.port ? a_rdata : b_rdata}, {24'd0, other_rd0});
        if (!v.we)
            check($sformatf("v%0d_rdata", idx), {24'd0, rd}, {24'd0, v.exp_rd});
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ia, ib, nord, ovl, bad, lat;
        logic order [8];
        logic [7:0] rd;

        for (int i = 0; i < 512; i++) begin
            mem1[i] = init_val(9'(i));
            mem3[i] = init_val(9'(i));
        end

        vt[0] = '{1'b0, 1'b1, 9'h005, 8'hA5, 8'h00, 2, 1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b0, 9'h005, 8'h00, 8'hA5, 3, 1'b0, 1'b0};
        vt[2] = '{1'b1, 1'b1, 9'h1FF, 8'h3C, 8'h00, 2, 1'b0, 1'b0};
        vt[3] = '{1'b0, 1'b0, 9'h1FF, 8'h00, 8'h3C, 3, 1'b0, 1'b0};
        vt[4] = '{1'b0, 1'b1, 9'h000, 8'hFF, 8'h00, 2, 1'b0, 1'b1};
        vt[5] = '{1'b1, 1'b0, 9'h000, 8'h00, 8'hFF, 3, 1'b0, 1'b0};
        vt[6] = '{1'b0, 1'b0, 9'h010, 8'h00, 8'h2C, 3, 1'b1, 1'b0};
        vt[7] = '{1'b1, 1'b0, 9'h005, 8'h00, 8'hA5, 3, 1'b0, 1'b0};

        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        a3_req = 0; a3_we = 0; a3_addr = '0; a3_wdata = '0;
        b3_req = 0; b3_we = 0; b3_addr = '0; b3_wdata = '0;
        rst_n = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_outputs_zero", {31'd0, any_out1()}, 0);
        check("reset_outputs_zero_lat3", {31'd0, any_out3()}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) run_txn(i, vt[i]);

        // Both ports reading continuously; last grant was B so A goes first.
        ia = 0; ib = 0; nord = 0; ovl = 0;
        a_we = 0; b_we = 0; a_addr = 9'h030; b_addr = 9'h040;
        a_req = 1; b_req = 1;
        for (int c = 0; c < 100 && (ia < 4 || ib < 4); c++) begin
            @(negedge clk);
            if ((a_ack && b_ack) || (gnt_a && gnt_b)) ovl++;
            if (a_ack) begin
                check($sformatf("fair_a%0d_data", ia), {24'd0, a_rdata}, {24'd0, init_val(9'(9'h030 + ia))});
                if (nord < 8) order[nord] = 1'b0;
                nord++; ia++;
                if (ia == 4) a_req = 0; else a_addr = 9'(9'h030 + ia);
            end
            if (b_ack) begin
                check($sformatf("fair_b%0d_data", ib), {24'd0, b_rdata}, {24'd0, init_val(9'(9'h040 + ib))});
                if (nord < 8) order[nord] = 1'b1;
                nord++; ib++;
                if (ib == 4) b_req = 0; else b_addr = 9'(9'h040 + ib);
            end
        end
        a_req = 0; b_req = 0;
        check("fair_total_acks", nord, 8);
        check("fair_overlap", ovl, 0);
        for (int i = 0; i < 8 && i < nord; i++)
            check($sformatf("fair_order_%0d", i), {31'd0, order[i]}, i % 2);
        @(posedge clk);
        #1;

        // Reset while the read is in RDWAIT.
        a_we = 0; a_addr = 9'h010; a_req = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_mid_granted", {31'd0, gnt_a}, 1);
        #1;
        rst_n = 1'b0;
        a_req = 0;
        #1;
        check("rst_mid_outputs_zero", {31'd0, any_out1()}, 0);
        repeat (3) @(negedge clk);
        check("rst_mid_held_zero", {31'd0, any_out1()}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_txn(8, '{1'b0, 1'b0, 9'h010, 8'h00, 8'h2C, 3, 1'b0, 1'b0});

        // RD_LAT = 3 instance: port B read, ack in cycle 5.
        b3_we = 0; b3_addr = 9'h005; b3_req = 1;
        lat = 0; bad = 0; rd = '0;
        @(posedge clk);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k <= 4 && mem3_raddr !== 9'h005) bad++;
            if (a3_ack || gnt3_a) bad++;
            if (b3_ack) begin lat = k; rd = b3_rdata; break; end
        end
        b3_req = 0;
        check("lat3_latency", lat, 5);
        check("lat3_rdata", {24'd0, rd}, {24'd0, init_val(9'h005)});
        check("lat3_raddr_stable", bad, 0);
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-wide program/data memory between two requesters.
- Port A is the CPU. Port B is the host/loader, used for program download and register-dump readback.
- Per-port req/ack handshake; round-robin choice on ties; one transaction in flight at a time.
- Drives the memory's separate read and write address buses and accounts for the memory's registered read latency.

Parameters:
- addr_width, 9, width of every address bus.
- RD_LAT, 1, memory read latency in cycles: cycles from mem_raddr valid to mem_data_out valid (range 1..4).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- a_req  in  1  port A request; held with a_we/a_addr/a_wdata until a_ack.
- a_we  in  1  port A: 1 = write, 0 = read.
- a_addr  in  addr_width  port A byte address.
- a_wdata  in  8  port A write data.
- a_rdata  out  8  port A read data; valid in the a_ack cycle.
- a_ack  out  1  port A one-cycle completion pulse.
- b_req, b_we, b_addr, b_wdata, b_rdata, b_ack  same as port A, for port B.
- gnt_a  out  1  port A owns memory, ACCESS through DONE.
- gnt_b  out  1  port B owns memory, ACCESS through DONE.
- mem_raddr  out  addr_width  memory read address.
- mem_waddr  out  addr_width  memory write address.
- mem_data_in  out  8  memory write data.
- mem_write  out  1  memory write strobe.
- mem_data_out  in  8  memory read data.

Behaviour:
- Reset (reset low, async): state IDLE, last_grant = B, all outputs 0.
  - A mid-transaction reset abandons the transaction: no ack, no further mem_write.
  - A write whose strobe was already high in that cycle is not guaranteed.
- States: IDLE, ACCESS, RDWAIT, DONE.
- IDLE (cycle 0): sample a_req/b_req.
  - Only one requesting: grant it.
  - Both requesting: grant the port != last_grant.
  - Latch we, addr and wdata of the winner, update last_grant, go to ACCESS.
  - Neither requesting: stay in IDLE.
- ACCESS (cycle 1): gnt_x = 1.
  - Read: mem_raddr = latched addr; load counter with RD_LAT; go to RDWAIT.
  - Write: mem_waddr = addr, mem_data_in = wdata, mem_write = 1 for exactly this cycle; go to DONE.
- RDWAIT: decrement the counter each cycle.
  - When the counter hits 0, capture mem_data_out into x_rdata and go to DONE.
- DONE: x_ack = 1 for one cycle; x_rdata holds the captured byte; then go to IDLE.
  - The ack cycle never re-samples requests, so a requester dropping req on ack is never served twice.
- Latency from the sample cycle:
  - Write ack in cycle 2.
  - Read ack in cycle RD_LAT+2; cycle 3 for RD_LAT = 1.
  - Back-to-back throughput: write every 3 cycles, read every RD_LAT+3 cycles.
- Address and data stability:
  - mem_raddr, mem_waddr and mem_data_in are registered.
  - They hold their last values when idle.
  - mem_raddr is stable from ACCESS until capture.
- Requester contract: request fields must be stable while req = 1. The arbiter uses latched copies, so changes after cycle 0 are ignored.
- Port separation: x_rdata of the non-granted port is unchanged. a_ack and b_ack are never high together.
- Fairness: with both ports requesting continuously, grants alternate A, B, A, B…; neither port waits more than one transaction.
- mem_write is 0 in every state except write ACCESS.
- A req dropped before grant is ignored (no ack). A req dropped after grant still completes and acks.

Decomposition:
- Shared package mem_pkg:
  - arbiter state encoding (2-bit enum).
  - port index constants PORT_A = 0, PORT_B = 1.
  - memory data width constant 8.
- One natural sub-module, rr_pick2: combinational two-way round-robin pick from req vector + last_grant. The FSM, latches and latency counter stay in mem_arbiter.

Test Plan:
- Reset low mid-read (RDWAIT) -> all outputs 0 immediately. After release, a_req read 0x010 is served normally with no stale ack.
- a_req write addr 0x005, data 0xA5 -> mem_write high exactly cycle 1 with mem_waddr = 0x005, mem_data_in = 0xA5. a_ack in cycle 2; gnt_b stays 0.
- b_req read addr 0x005 after that write, memory model RD_LAT = 1 -> mem_raddr = 0x005 from cycle 1, b_ack in cycle 3 with b_rdata = 0xA5. Repeat with RD_LAT = 3 -> b_ack in cycle 5.
- a_req and b_req both asserted continuously for 4 reads each -> grant order A, B, A, B, A, B, A, B. Each port receives 4 acks and correct data, never overlapping.
- b_req pulsed one cycle while port A is in ACCESS -> no b_ack ever. Port A read completes unaffected.
- a_req held high through a_ack for one extra cycle, then dropped -> exactly one transaction, one mem_write for a write; the DONE cycle does not re-grant.
